// File: rtl/siso_pkg.sv
// Shared definitions for the SISO serializer controller.
//   state_t   : controller state encoding (IDLE, SHIFT, DONE)
//   cnt_width : width of a bit counter able to hold the value WIDTH
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/siso_hold_shifter.sv
// Holding register and shift logic for the SISO serializer.
// Ports:
//   clk     : clock, rising edge
//   clear_n : asynchronous active-low reset, clears the holding register
//   load    : capture d into the holding register
//   shift   : shift one position toward the output bit, filling with 0
//   d       : parallel word to capture
//   q_bit   : current output bit (bit 0, or bit WIDTH-1 when MSB_FIRST)
module siso_hold_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] hold;

  // load has priority; in the controller the two are never active together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hold <= '0;
    end else if (load) begin
      hold <= d;
    end else if (shift) begin
      hold <= MSB_FIRST ? {hold[WIDTH-2:0], 1'b0} : {1'b0, hold[WIDTH-1:1]};
    end
  end

  assign q_bit = MSB_FIRST ? hold[WIDTH-1] : hold[0];

endmodule

// File: rtl/siso_ser_ctrl.sv
// Parallel-to-serial controller driving a downstream SISO shift register.
// Accepts a WIDTH-bit word on a valid/ready handshake, then presents it one
// bit per cycle on si with shift_en high for WIDTH cycles, followed by a
// one-cycle done pulse. abort cancels a word in flight (aborted pulse).
// Ports:
//   clk, clear_n           : clock, asynchronous active-low reset
//   load_valid, load_data  : word offered
//   load_ready             : word accepted this cycle when load_valid is high
//   abort                  : cancel the word in flight
//   shift_en, si           : clock-enable and serial bit to the shift register
//   busy                   : controller not idle
//   done, aborted          : one-cycle completion / abort-confirm pulses
module siso_ser_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             shift_en,
  output logic             si,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          aborted_q;
  logic          accept;
  logic          q_bit;

  assign load_ready = (state == IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort is checked before the last-bit test so it wins on the final shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter reaches WIDTH on the last shift and then leaves SHIFT, so the
  // CW-bit register never wraps.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Confirm an abort only when a word was actually in flight.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort && (state != IDLE);
    end
  end

  siso_hold_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_hold (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (accept),
    .shift   (shift_en),
    .d       (load_data),
    .q_bit   (q_bit)
  );

  assign shift_en = (state == SHIFT);
  // Gate so that si is 0 (and never X) outside the shift window.
  assign si       = shift_en & q_bit;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_siso_ser_ctrl.sv
module tb_siso_ser_ctrl;

  localparam int W       = 8;
  localparam int K_BIT   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic b0;
    logic b1;
  } ev_t;

  logic         clk;
  logic         clear_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         abort;

  logic load_ready_a, shift_en_a, si_a, busy_a, done_a, aborted_a;
  logic load_ready_b, shift_en_b, si_b, busy_b, done_b, aborted_b;

  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;
  ev_t q[$];
  ev_t mon_e;

  siso_ser_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .clear_n    (clear_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready_a),
    .abort      (abort),
    .shift_en   (shift_en_a),
    .si         (si_a),
    .busy       (busy_a),
    .done       (done_a),
    .aborted    (aborted_a)
  );

  siso_ser_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .clear_n    (clear_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready_b),
    .abort      (abort),
    .shift_en   (shift_en_b),
    .si         (si_b),
    .busy       (busy_b),
    .done       (done_b),
    .aborted    (aborted_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_shift_en_lsb"}, shift_en_a, 0);
    chk({tag, "_si_lsb"},       si_a,       0);
    chk({tag, "_busy_lsb"},     busy_a,     0);
    chk({tag, "_done_lsb"},     done_a,     0);
    chk({tag, "_aborted_lsb"},  aborted_a,  0);
    chk({tag, "_shift_en_msb"}, shift_en_b, 0);
    chk({tag, "_si_msb"},       si_b,       0);
    chk({tag, "_busy_msb"},     busy_b,     0);
    chk({tag, "_done_msb"},     done_b,     0);
    chk({tag, "_aborted_msb"},  aborted_b,  0);
  endtask

  // Reference: the k-th serial bit (k = 1..W) for each bit order.
  function automatic logic bit_lsb(input logic [W-1:0] w, input int k);
    return logic'((w >> (k - 1)) & 1);
  endfunction

  function automatic logic bit_msb(input logic [W-1:0] w, input int k);
    return logic'((w >> (W - k)) & 1);
  endfunction

  // One word: gap idle cycles (last one optionally with abort+valid, which
  // must not be accepted), acceptance, then the busy window. ab_at = 0 means
  // no abort, otherwise abort is asserted in shift cycle ab_at (1..W).
  task automatic run_word(input logic [W-1:0] w, input int gap, input bit idle_abort,
                          input int ab_at, input bit hold, input logic [W-1:0] busy_data);
    int c0;
    int nb;
    int last;
    for (int g = 0; g < gap; g++) begin
      load_valid = idle_abort && (g == gap - 1);
      abort      = load_valid;
      load_data  = W'($urandom);
      step();
    end
    load_valid = 1'b1;
    abort      = 1'b0;
    load_data  = w;
    c0         = cyc;
    step();
    last = (ab_at == 0) ? W : ab_at;
    for (int k = 1; k <= last; k++)
      q.push_back('{kind: K_BIT, cyc: c0 + k, b0: bit_lsb(w, k), b1: bit_msb(w, k)});
    if (ab_at == 0)
      q.push_back('{kind: K_DONE, cyc: c0 + W + 1, b0: 1'b0, b1: 1'b0});
    else
      q.push_back('{kind: K_ABORT, cyc: c0 + ab_at + 1, b0: 1'b0, b1: 1'b0});
    nb = (ab_at == 0) ? W + 1 : ab_at;
    for (int k = 1; k <= nb; k++) begin
      load_valid = hold ? 1'b1 : 1'($urandom);
      load_data  = hold ? busy_data : W'($urandom);
      abort      = (k == ab_at);
      step();
    end
    abort      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic reset_mid(input logic [W-1:0] w, input int ka);
    int c0;
    load_valid = 1'b1;
    abort      = 1'b0;
    load_data  = w;
    c0         = cyc;
    step();
    load_valid = 1'b0;
    for (int k = 1; k < ka; k++)
      q.push_back('{kind: K_BIT, cyc: c0 + k, b0: bit_lsb(w, k), b1: bit_msb(w, k)});
    for (int k = 1; k < ka; k++) step();
    #2;
    clear_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    step();
    clear_n = 1'b1;
    #1;
    chk("ready_after_release_lsb", load_ready_a, 1);
    chk("ready_after_release_msb", load_ready_b, 1);
  endtask

  // Monitor: pops an expected event whenever a DUT shows shift_en/done/aborted.
  initial begin
    forever begin
      @(negedge clk);
      if (!clear_n) continue;
      if (shift_en_a | done_a | aborted_a | shift_en_b | done_b | aborted_b) begin
        if (q.size() == 0) begin
          chk("unexpected_output_lsb", {shift_en_a, done_a, aborted_a}, 3'b000);
          chk("unexpected_output_msb", {shift_en_b, done_b, aborted_b}, 3'b000);
        end else begin
          mon_e = q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("flags_lsb", {shift_en_a, done_a, aborted_a},
              {mon_e.kind == K_BIT, mon_e.kind == K_DONE, mon_e.kind == K_ABORT});
          chk("flags_msb", {shift_en_b, done_b, aborted_b},
              {mon_e.kind == K_BIT, mon_e.kind == K_DONE, mon_e.kind == K_ABORT});
          chk("si_lsb", si_a, (mon_e.kind == K_BIT) ? mon_e.b0 : 1'b0);
          chk("si_msb", si_b, (mon_e.kind == K_BIT) ? mon_e.b1 : 1'b0);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        chk("missing_event_lsb", {shift_en_a, done_a, aborted_a},
            {mon_e.kind == K_BIT, mon_e.kind == K_DONE, mon_e.kind == K_ABORT});
      end
      chk("si_gated_lsb", si_a & ~shift_en_a, 0);
      chk("si_gated_msb", si_b & ~shift_en_b, 0);
      chk("busy_lsb", busy_a, shift_en_a | done_a);
      chk("busy_msb", busy_b, shift_en_b | done_b);
      if (!busy_a) chk("ready_lsb", load_ready_a, !abort);
      if (!busy_b) chk("ready_msb", load_ready_b, !abort);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int ab_at;
    clear_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    abort      = 1'b0;
    #3;
    chk_zero("reset");
    step();
    step();
    clear_n = 1'b1;
    #1;
    chk("ready_after_reset_lsb", load_ready_a, 1);
    chk("ready_after_reset_msb", load_ready_b, 1);

    run_word(8'hA5, 0, 1'b0, 0, 1'b0, 8'h00);
    run_word(8'h01, 1, 1'b0, 0, 1'b1, 8'h80);
    run_word(8'h80, 0, 1'b0, 0, 1'b0, 8'h00);
    run_word(W'($urandom), 1, 1'b0, 4, 1'b0, 8'h00);
    run_word(W'($urandom), 0, 1'b0, W, 1'b0, 8'h00);
    run_word(8'h5A, 2, 1'b1, 0, 1'b0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      gap   = $urandom_range(0, 3);
      ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W) : 0;
      run_word(W'($urandom), gap, (gap > 0) && ($urandom_range(0, 3) == 0), ab_at,
               1'($urandom), W'($urandom));
    end

    reset_mid(8'hC3, 3);
    run_word(8'h3C, 0, 1'b0, 0, 1'b0, 8'h00);

    repeat (W + 4) step();
    chk("queue_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/siso_ser_ctrl.md
SISO_SER_CTRL -- requirements
Module: siso_ser_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning 0 = LSB shifted first and 1 = MSB shifted first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: a parallel word is offered.
REQ-006 SHALL have port load_data, input, WIDTH bits: the word to serialize.
REQ-007 SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port abort, input, 1 bit: cancels the word in flight.
REQ-009 SHALL have port shift_en, output, 1 bit: clock-enable to the downstream SISO shift register.
REQ-010 SHALL have port si, output, 1 bit: serial bit presented to the shift register; valid while shift_en=1.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word is shifted.
REQ-013 SHALL have port aborted, output, 1 bit: one-cycle pulse confirming an abort.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE, each registered.
REQ-015 load_ready SHALL equal (state==IDLE) and not abort; it SHALL be purely combinational from state and abort.
REQ-016 Handshake: a word SHALL be accepted on a rising edge when load_valid and load_ready are both 1; the word SHALL be captured into an internal WIDTH-bit holding register, bit counter = 0, and the state SHALL become SHIFT.
REQ-017 In SHIFT, shift_en SHALL be 1 for exactly WIDTH consecutive cycles, starting the cycle after acceptance.
REQ-018 In SHIFT, si SHALL present holding-register bit 0 when MSB_FIRST=0, or bit WIDTH-1 when MSB_FIRST=1.
REQ-019 On each SHIFT edge, the holding register SHALL shift by one toward the output bit, filling with 0.
REQ-020 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL increment on each SHIFT edge.
REQ-021 When counter==WIDTH-1 in SHIFT, the next state SHALL be DONE; the counter SHALL never wrap.
REQ-022 In DONE, done SHALL be 1 and shift_en SHALL be 0 for one cycle, then the state SHALL return to IDLE.
REQ-023 Latency SHALL be fixed: acceptance at cycle 0, shift_en in cycles 1..WIDTH, done in cycle WIDTH+1, load_ready again in cycle WIDTH+2; back-to-back words SHALL therefore be WIDTH+2 cycles apart.
REQ-024 load_data and load_valid SHALL be ignored outside IDLE, with no corruption of the word in flight.
REQ-025 abort in SHIFT or DONE SHALL move the state to IDLE on the next edge, with shift_en=0 from that edge; aborted SHALL pulse for one cycle and done SHALL NOT pulse.
REQ-026 abort in IDLE SHALL have no effect other than blocking acceptance in that cycle; aborted SHALL NOT pulse.
REQ-027 If abort coincides with the final SHIFT cycle, abort SHALL win: no done pulse, aborted pulses.
REQ-028 si SHALL be 0 whenever shift_en=0.
REQ-029 An X on load_data SHALL propagate to si only while shift_en=1.

Reset
REQ-030 clear_n=0 SHALL immediately force: state=IDLE, counter=0, holding register=0, shift_en=0, si=0, done=0, aborted=0, busy=0.
REQ-031 Reset asserted mid-word SHALL discard the word with no done or aborted pulse.
REQ-032 After reset deassertion, load_ready SHALL be 1 in the first cycle (provided abort=0).

Structure
REQ-033 A shared package siso_pkg SHALL hold the state enumeration and the counter-width function.
REQ-034 The holding register plus shift logic SHALL be a sub-module named siso_hold_shifter (ports: clk, clear_n, load, shift, d, q_bit); the FSM and counter SHALL stay in the top module.

Verification
REQ-035 Scenario: WIDTH=8, MSB_FIRST=0, load 8'hA5 -> si sequence 1,0,1,0,0,1,0,1 in cycles 1..8; done in cycle 9; load_ready in cycle 10.
REQ-036 Scenario: MSB_FIRST=1, load 8'hA5 -> si sequence 1,0,1,0,0,1,0,1 (MSB first), with timing identical to REQ-035.
REQ-037 Scenario: load_valid held high with 8'h01 then 8'h80 -> words accepted exactly 10 cycles apart; the second word is not sampled during busy.
REQ-038 Scenario: abort in cycle 4 of a word -> shift_en=0 from cycle 5, aborted pulses, done stays 0, load_ready returns.
REQ-039 Scenario: clear_n pulsed low mid-SHIFT, asynchronous to clk -> all outputs 0 immediately; the next word after release serializes correctly.
REQ-040 Scenario: abort coincides with the final shift cycle -> aborted=1 and done=0.
